mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares one single-ported, multi-cycle SRAM between instruction fetch (IF) and the MEM stage.
// - Sequences each access: drives the SRAM, counts wait states and captures read data.
// - Drives the pipeline-wide freeze until every request pending in the current pipeline cycle is served.
// - MEM stage has priority over IF because it carries the older instruction.
// PARAMETERS
// WAIT_CYCLES  5      SRAM access time in clk cycles (>=1); address/data held stable for this long
// ADDR_W       16     SRAM word-address width
// BASE_ADDR    1024   byte address mapped to SRAM word 0 (data accesses only)
// PORTS
// clk            in   1       system clock, rising edge
// rst            in   1       asynchronous reset, active-low
// ifReq          in   1       IF requests an instruction read
// ifAddress      in   32      IF byte address (PC)
// ifData         out  32      fetched instruction; registered, held until the next IF access completes
// memReadReq     in   1       MEM stage load request
// memWriteReq    in   1       MEM stage store request
// memAddress     in   32      MEM byte address (ALU result)
// memWriteData   in   32      store data
// memReadData    out  32      load data; registered, held until the next MEM read completes
// freeze         out  1       stall IF/ID/EXE/MEM pipeline registers
// sramAddr       out  ADDR_W  SRAM word address
// sramWData      out  32      SRAM write data
// sramWe         out  1       SRAM write enable, active-high
// sramRData      in   32      SRAM read data, valid at end of the WAIT_CYCLES-th access cycle
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; counter=0; sramWe=0; sramAddr=0; sramWData=0; ifData=0; memReadData=0.
// - Reset is released synchronously into IDLE. Reset mid-access aborts the access and deasserts sramWe immediately.
// - FSM states: IDLE, MEM_ACC, IF_ACC, DONE.
//   - IDLE: if memReadReq|memWriteReq -> MEM_ACC; else if ifReq -> IF_ACC; else stay in IDLE.
//   - MEM_ACC/IF_ACC: counter loads WAIT_CYCLES-1 on entry and decrements each cycle; the access ends when counter==0.
//   - MEM_ACC end: capture memReadData for a load. Then -> IF_ACC if ifReq, else -> DONE.
//   - IF_ACC end: capture ifData; -> DONE.
//   - DONE: lasts one cycle; -> IDLE. No new grant is issued from DONE.
// - freeze = (ifReq|memReadReq|memWriteReq) && state!=DONE.
//   - Combinational from the request inputs and registered state.
//   - Consequence: the pipeline advances exactly on the DONE-cycle edge.
// - Latency, IF only: request high in IDLE at edge k; freeze falls in cycle k+WAIT_CYCLES+1 (DONE).
// - Latency, MEM and IF together: DONE comes 2*WAIT_CYCLES+1 cycles after the grant.
// - Address mapping:
//   - MEM accesses: sramAddr = (memAddress-BASE_ADDR)[ADDR_W+1:2].
//   - IF accesses: sramAddr = ifAddress[ADDR_W+1:2].
//   - Byte bits [1:0] are ignored. Out-of-range addresses wrap modulo 2^ADDR_W words; no error is flagged.
// - Store: sramWe=1 for all WAIT_CYCLES cycles of MEM_ACC, with address and data registered at grant.
//   sramWe=0 in every other state.
// - memReadReq and memWriteReq both high is illegal; the write wins and memReadData is not updated.
// - Requests must stay stable while freeze=1. Any change after grant is ignored until DONE.
// - An ifReq that falls during MEM_ACC is not serviced.
// STRUCTURE
// - Shared package arm_defs_pkg:
//   - state enum {IDLE, MEM_ACC, IF_ACC, DONE}
//   - constants SRAM_WAIT_DEFAULT=5 and DATA_BASE_ADDR=1024.
// - One sub-module: wait_counter (load/decrement/zero flag, width $clog2(WAIT_CYCLES+1)).
// - FSM, address mapping and data capture stay in this module.
// TESTING
// - Reset: drive rst=0 mid-access with WAIT_CYCLES=5.
//   -> all outputs 0 at once; after release, state IDLE.
// - IF only: ifReq=1, ifAddress=0x8, sramRData=0xE3A00001.
//   -> sramAddr=2, freeze=1 for 6 cycles; ifData=0xE3A00001 in cycle 7; freeze=0 for exactly 1 cycle.
// - Load plus fetch: memReadReq=1, memAddress=1028, ifReq=1.
//   -> MEM first with sramAddr=1; then IF; freeze high for 11 cycles; both data registers updated.
// - Store: memWriteReq=1, memAddress=1032, memWriteData=0xDEADBEEF.
//   -> sramWe=1 for exactly 5 cycles at sramAddr=2; memReadData unchanged.
// - Conflict: memReadReq=memWriteReq=1.
//   -> write performed; memReadData holds its previous value.
// - Wrap: memAddress=1024+4*2^16.
//   -> sramAddr=0; WAIT_CYCLES=1 variant gives freeze high for 2 cycles only.

Source files
------------

// File: rtl/arm_defs_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding and
// default SRAM timing/address-map constants.
package arm_defs_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_ACC = 2'd1,
        IF_ACC  = 2'd2,
        DONE    = 2'd3
    } arb_state_e;

    localparam int unsigned SRAM_WAIT_DEFAULT = 5;
    localparam int unsigned DATA_BASE_ADDR    = 1024;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline request/response and SRAM bus bundle for the memory-port arbiter.
// The slave modport is the arbiter; the master modport is the pipeline + SRAM side.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              ifReq;
    logic [31:0]       ifAddress;
    logic [31:0]       ifData;
    logic              memReadReq;
    logic              memWriteReq;
    logic [31:0]       memAddress;
    logic [31:0]       memWriteData;
    logic [31:0]       memReadData;
    logic              freeze;
    logic [ADDR_W-1:0] sramAddr;
    logic [31:0]       sramWData;
    logic              sramWe;
    logic [31:0]       sramRData;

    modport slave (
        input  ifReq, ifAddress, memReadReq, memWriteReq, memAddress, memWriteData, sramRData,
        output ifData, memReadData, freeze, sramAddr, sramWData, sramWe
    );

    modport master (
        output ifReq, ifAddress, memReadReq, memWriteReq, memAddress, memWriteData, sramRData,
        input  ifData, memReadData, freeze, sramAddr, sramWData, sramWe
    );
endinterface

// File: rtl/wait_counter.sv
// SRAM wait-state counter: loads WAIT_CYCLES-1 when an access is granted and
// counts down to zero, which marks the last cycle of the access.
module wait_counter #(
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam int unsigned CW       = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one multi-cycle single-ported SRAM between instruction fetch and
// the MEM stage (MEM first), freezing the pipeline until all pending requests are served.
module mem_port_arbiter
    import arm_defs_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = SRAM_WAIT_DEFAULT,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned BASE_ADDR   = DATA_BASE_ADDR
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [31:0]       sram_wdata_q, sram_wdata_d;
    logic              sram_we_q, sram_we_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_read_data_q, mem_read_data_d;
    logic              is_write_q, is_write_d;

    logic              cnt_load, cnt_dec, cnt_zero;
    logic              mem_req, any_req;
    logic [ADDR_W-1:0] mem_word, if_word;

    assign mem_req  = bus.memReadReq | bus.memWriteReq;
    assign any_req  = mem_req | bus.ifReq;

    // Word addresses wrap silently modulo 2^ADDR_W; byte bits are dropped by the shift.
    assign mem_word = ADDR_W'((bus.memAddress - 32'(BASE_ADDR)) >> 2);
    assign if_word  = ADDR_W'(bus.ifAddress >> 2);

    wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_counter (
        .clk   (clk),
        .rst_n (rst),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    always_comb begin
        state_d         = state_q;
        sram_addr_d     = sram_addr_q;
        sram_wdata_d    = sram_wdata_q;
        sram_we_d       = sram_we_q;
        if_data_d       = if_data_q;
        mem_read_data_d = mem_read_data_q;
        is_write_d      = is_write_q;
        cnt_load        = 1'b0;
        cnt_dec         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_req) begin
                    state_d      = MEM_ACC;
                    cnt_load     = 1'b1;
                    sram_addr_d  = mem_word;
                    sram_wdata_d = bus.memWriteData;
                    sram_we_d    = bus.memWriteReq;
                    is_write_d   = bus.memWriteReq;
                end else if (bus.ifReq) begin
                    state_d     = IF_ACC;
                    cnt_load    = 1'b1;
                    sram_addr_d = if_word;
                    sram_we_d   = 1'b0;
                end
            end
            MEM_ACC: begin
                if (cnt_zero) begin
                    // A store with a read also requested counts as a store only.
                    if (!is_write_q) begin
                        mem_read_data_d = bus.sramRData;
                    end
                    sram_we_d = 1'b0;
                    if (bus.ifReq) begin
                        state_d     = IF_ACC;
                        cnt_load    = 1'b1;
                        sram_addr_d = if_word;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            IF_ACC: begin
                if (cnt_zero) begin
                    if_data_d = bus.sramRData;
                    state_d   = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            sram_addr_q     <= '0;
            sram_wdata_q    <= '0;
            sram_we_q       <= 1'b0;
            if_data_q       <= '0;
            mem_read_data_q <= '0;
            is_write_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            sram_addr_q     <= sram_addr_d;
            sram_wdata_q    <= sram_wdata_d;
            sram_we_q       <= sram_we_d;
            if_data_q       <= if_data_d;
            mem_read_data_q <= mem_read_data_d;
            is_write_q      <= is_write_d;
        end
    end

    // The pipeline advances on the edge that ends the single DONE cycle.
    assign bus.freeze      = any_req && (state_q != DONE);
    assign bus.sramAddr    = sram_addr_q;
    assign bus.sramWData   = sram_wdata_q;
    assign bus.sramWe      = sram_we_q;
    assign bus.ifData      = if_data_q;
    assign bus.memReadData = mem_read_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected transaction results are queued
// as stimulus is applied and compared when the arbiter releases freeze.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(16)) bus  ();
    mem_port_arbiter_if #(.ADDR_W(16)) bus1 ();

    mem_port_arbiter #(.WAIT_CYCLES(5), .ADDR_W(16), .BASE_ADDR(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_port_arbiter #(.WAIT_CYCLES(1), .ADDR_W(16), .BASE_ADDR(1024)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // SRAM model: preset contents per word until the arbiter writes that word.
    logic [31:0] sram_data [0:255];
    bit          sram_wr   [0:255];
    logic [7:0]  sram_idx;

    function automatic logic [31:0] init_word(input logic [7:0] a);
        case (a)
            8'd1:    return 32'hA5A5_0001;
            8'd2:    return 32'hE3A0_0001;
            8'd3:    return 32'h1122_3344;
            default: return {24'h5555_00, a};
        endcase
    endfunction

    assign sram_idx = bus.sramAddr[7:0];
    always_comb bus.sramRData = sram_wr[sram_idx] ? sram_data[sram_idx] : init_word(sram_idx);
    always @(posedge clk) begin
        if (bus.sramWe === 1'b1) begin
            sram_data[sram_idx] <= bus.sramWData;
            sram_wr[sram_idx]   <= 1'b1;
        end
    end
    assign bus1.sramRData = 32'h0F0F_0F0F;

    typedef struct {
        int          freeze_cyc;
        int          we_cyc;
        logic [15:0] addr0;
        bit          chk_addr1;
        logic [15:0] addr1;
        logic [31:0] wdata;
        logic [31:0] if_data;
        logic [31:0] mem_data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push_exp(input int fc, input int wc, input logic [15:0] a0, input bit c1,
                            input logic [15:0] a1, input logic [31:0] wd,
                            input logic [31:0] ifd, input logic [31:0] memd);
        exp_t e;
        e.freeze_cyc = fc; e.we_cyc = wc; e.addr0 = a0; e.chk_addr1 = c1; e.addr1 = a1;
        e.wdata = wd; e.if_data = ifd; e.mem_data = memd;
        sb.push_back(e);
    endtask

    task automatic drop_reqs();
        bus.ifReq = 1'b0; bus.memReadReq = 1'b0; bus.memWriteReq = 1'b0;
        bus1.ifReq = 1'b0; bus1.memReadReq = 1'b0; bus1.memWriteReq = 1'b0;
    endtask

    // Applies one pipeline-cycle request set and checks it against the head of the scoreboard.
    task automatic run_op(input string name, input logic ifr, input logic mr, input logic mw,
                          input logic [31:0] ia, input logic [31:0] ma, input logic [31:0] wd);
        exp_t        e;
        int          n;
        int          we_n;
        logic [31:0] wd_seen;
        logic [15:0] addrs[$];
        @(negedge clk);
        bus.ifReq = ifr; bus.memReadReq = mr; bus.memWriteReq = mw;
        bus.ifAddress = ia; bus.memAddress = ma; bus.memWriteData = wd;
        #1;
        n = 0; we_n = 0; wd_seen = '0;
        while (bus.freeze === 1'b1 && n < 100) begin
            n++;
            if (n > 1) begin
                addrs.push_back(bus.sramAddr);
                if (bus.sramWe === 1'b1) begin
                    we_n++;
                    wd_seen = bus.sramWData;
                end
            end
            @(negedge clk); #1;
        end
        checks++;
        if (n >= 100) begin
            errors++; $display("FAIL %s timeout: freeze still high after %0d cycles", name, n);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++; $display("FAIL %s scoreboard empty", name);
            drop_reqs();
            return;
        end
        e = sb.pop_front();
        checks++;
        if (n !== e.freeze_cyc) begin
            errors++; $display("FAIL %s freeze_cycles got %0d want %0d", name, n, e.freeze_cyc);
        end
        checks++;
        if (we_n !== e.we_cyc) begin
            errors++; $display("FAIL %s we_cycles got %0d want %0d", name, we_n, e.we_cyc);
        end
        checks++;
        if (addrs.size() == 0 || addrs[0] !== e.addr0) begin
            errors++; $display("FAIL %s first_addr got %0h want %0h", name,
                               (addrs.size() == 0) ? 16'hxxxx : addrs[0], e.addr0);
        end
        if (e.chk_addr1) begin
            checks++;
            if (addrs.size() < 6 || addrs[5] !== e.addr1) begin
                errors++; $display("FAIL %s second_addr got %0h want %0h", name,
                                   (addrs.size() < 6) ? 16'hxxxx : addrs[5], e.addr1);
            end
        end
        if (e.we_cyc > 0) begin
            checks++;
            if (wd_seen !== e.wdata) begin
                errors++; $display("FAIL %s wdata got %08h want %08h", name, wd_seen, e.wdata);
            end
        end
        checks++;
        if (bus.sramWe !== 1'b0) begin
            errors++; $display("FAIL %s we_in_done got %b want 0", name, bus.sramWe);
        end
        checks++;
        if (bus.ifData !== e.if_data) begin
            errors++; $display("FAIL %s ifData got %08h want %08h", name, bus.ifData, e.if_data);
        end
        checks++;
        if (bus.memReadData !== e.mem_data) begin
            errors++; $display("FAIL %s memReadData got %08h want %08h", name, bus.memReadData, e.mem_data);
        end
        // Requests still held: the DONE gap must be exactly one cycle.
        @(negedge clk); #1;
        checks++;
        if (bus.freeze !== 1'b1) begin
            errors++; $display("FAIL %s freeze_after_done got %b want 1", name, bus.freeze);
        end
        drop_reqs();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drop_reqs();
        bus.ifAddress = '0; bus.memAddress = '0; bus.memWriteData = '0;
        bus1.ifAddress = '0; bus1.memAddress = '0; bus1.memWriteData = '0;
        #12;
        checks++;
        if (bus.sramWe !== 1'b0 || bus.sramAddr !== 16'h0 || bus.sramWData !== 32'h0 ||
            bus.ifData !== 32'h0 || bus.memReadData !== 32'h0 || bus.freeze !== 1'b0) begin
            errors++; $display("FAIL reset_state we=%b addr=%h wd=%h if=%h mem=%h frz=%b want all 0",
                               bus.sramWe, bus.sramAddr, bus.sramWData, bus.ifData, bus.memReadData, bus.freeze);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_if_only();
        push_exp(6, 0, 16'd2, 1'b0, 16'd0, 32'h0, 32'hE3A0_0001, 32'h0);
        run_op("if_only", 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0);
    endtask

    task automatic test_load_fetch();
        push_exp(11, 0, 16'd1, 1'b1, 16'd3, 32'h0, 32'h1122_3344, 32'hA5A5_0001);
        run_op("load_fetch", 1'b1, 1'b1, 1'b0, 32'hC, 32'd1028, 32'h0);
    endtask

    task automatic test_store();
        push_exp(6, 5, 16'd2, 1'b0, 16'd0, 32'hDEAD_BEEF, 32'h1122_3344, 32'hA5A5_0001);
        run_op("store", 1'b0, 1'b0, 1'b1, 32'h0, 32'd1032, 32'hDEAD_BEEF);
    endtask

    task automatic test_back_to_back();
        push_exp(6, 0, 16'd2, 1'b0, 16'd0, 32'h0, 32'hDEAD_BEEF, 32'hA5A5_0001);
        run_op("fetch_after_store", 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0);
    endtask

    task automatic test_conflict();
        push_exp(6, 5, 16'd4, 1'b0, 16'd0, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'hA5A5_0001);
        run_op("conflict", 1'b0, 1'b1, 1'b1, 32'h0, 32'd1040, 32'hCAFE_F00D);
    endtask

    task automatic test_wrap();
        push_exp(6, 5, 16'd0, 1'b0, 16'd0, 32'h0BAD_C0DE, 32'hDEAD_BEEF, 32'hA5A5_0001);
        run_op("wrap_store", 1'b0, 1'b0, 1'b1, 32'h0, 32'd1024 + 32'd4 * 32'd65536, 32'h0BAD_C0DE);
        push_exp(6, 0, 16'd0, 1'b0, 16'd0, 32'h0, 32'hDEAD_BEEF, 32'h0BAD_C0DE);
        run_op("wrap_load", 1'b0, 1'b1, 1'b0, 32'h0, 32'd1024, 32'h0);
    endtask

    task automatic test_wrap_w1();
        int          n;
        int          we_n;
        logic [15:0] a0;
        @(negedge clk);
        bus1.memWriteReq = 1'b1; bus1.memAddress = 32'd1024 + 32'd4 * 32'd65536; bus1.memWriteData = 32'h1357_9BDF;
        #1;
        n = 0; we_n = 0; a0 = 16'hFFFF;
        while (bus1.freeze === 1'b1 && n < 100) begin
            n++;
            if (n == 2) a0 = bus1.sramAddr;
            if (bus1.sramWe === 1'b1) we_n++;
            @(negedge clk); #1;
        end
        drop_reqs();
        checks++;
        if (n !== 2) begin
            errors++; $display("FAIL w1_freeze_cycles got %0d want 2", n);
        end
        checks++;
        if (a0 !== 16'h0 || we_n !== 1) begin
            errors++; $display("FAIL w1_access addr got %0h want 0, we_cycles got %0d want 1", a0, we_n);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.memWriteReq = 1'b1; bus.memAddress = 32'd1024 + 32'd32; bus.memWriteData = 32'h7777_7777;
        @(negedge clk); #1;
        checks++;
        if (bus.sramWe !== 1'b1 || bus.sramAddr !== 16'd8) begin
            errors++; $display("FAIL mid_store_active we=%b addr=%0h want we=1 addr=8", bus.sramWe, bus.sramAddr);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        drop_reqs();
        #1;
        checks++;
        if (bus.sramWe !== 1'b0 || bus.sramAddr !== 16'h0 || bus.sramWData !== 32'h0 ||
            bus.ifData !== 32'h0 || bus.memReadData !== 32'h0 || bus.freeze !== 1'b0) begin
            errors++; $display("FAIL reset_mid we=%b addr=%h wd=%h if=%h mem=%h frz=%b want all 0",
                               bus.sramWe, bus.sramAddr, bus.sramWData, bus.ifData, bus.memReadData, bus.freeze);
        end
        @(negedge clk);
        rst = 1'b1;
        push_exp(6, 0, 16'd2, 1'b0, 16'd0, 32'h0, 32'hDEAD_BEEF, 32'h0);
        run_op("fetch_after_reset", 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_if_only();
        test_load_fetch();
        test_store();
        test_back_to_back();
        test_conflict();
        test_wrap();
        test_wrap_w1();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
